// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state type, default timing and LFSR helpers for the mole game sequencer
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SHOW_ENTRY,
        SHOW,
        GAP_ENTRY,
        GAP,
        DONE,
        CLEAR
    } game_state_e;

    localparam int unsigned DEF_ARM_CYCLES  = 300_000_000;
    localparam int unsigned DEF_SHOW_CYCLES = 100_000_000;
    localparam int unsigned DEF_GAP_CYCLES  = 25_000_000;
    localparam int unsigned DEF_NUM_ROUNDS  = 30;
    localparam logic [15:0] DEF_SEED        = 16'hACE1;

    // Galois form of x^16+x^14+x^13+x^11, shifting right
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // An all-zero seed would lock the LFSR up
    function automatic logic [15:0] seed_or_default(input logic [15:0] s);
        return (s == 16'h0000) ? DEF_SEED : s;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - control/score bus between the round sequencer and the scorer side
interface game_sequencer_if;

    logic       start;
    logic       abort;
    logic [7:0] molehit;
    logic       gamestart;
    logic       gameend;
    logic       enable;
    logic [7:0] mole_pos;
    logic [7:0] rounds_left;
    logic       busy;

    modport master (
        input  start, abort, molehit,
        output gamestart, gameend, enable, mole_pos, rounds_left, busy
    );

    modport slave (
        output start, abort, molehit,
        input  gamestart, gameend, enable, mole_pos, rounds_left, busy
    );

endinterface

// File: rtl/mole_lfsr.sv
// rtl/mole_lfsr.sv - free-running 16-bit Galois LFSR with no-immediate-repeat mole index pick
module mole_lfsr
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_SEED
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] prev_idx_i,
    output logic [2:0] idx_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = lfsr_step(lfsr_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= seed_or_default(SEED);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // 3-bit add wraps 7 back to 0
    assign idx_o = (lfsr_q[2:0] == prev_idx_i) ? (lfsr_q[2:0] + 3'd1) : lfsr_q[2:0];

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - countdown plus show/gap round controller driving the mole scorer
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned ARM_CYCLES  = DEF_ARM_CYCLES,
    parameter int unsigned SHOW_CYCLES = DEF_SHOW_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned NUM_ROUNDS  = DEF_NUM_ROUNDS,
    parameter logic [15:0] SEED        = DEF_SEED
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    game_sequencer_if.master  bus
);

    if (ARM_CYCLES == 0 || SHOW_CYCLES == 0 || GAP_CYCLES == 0 ||
        NUM_ROUNDS == 0 || NUM_ROUNDS > 255) begin : g_bad_params
        $error("game_sequencer: cycle counts must be nonzero and NUM_ROUNDS in 1..255");
    end

    localparam logic [31:0] ARM_LOAD    = 32'(ARM_CYCLES - 1);
    localparam logic [31:0] SHOW_LOAD   = 32'(SHOW_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD    = 32'(GAP_CYCLES - 1);
    localparam logic [7:0]  ROUNDS_LOAD = 8'(NUM_ROUNDS);

    game_state_e state_q;
    logic [31:0] cnt_q;
    logic [2:0]  prev_idx_q;
    logic [2:0]  idx;
    logic        gamestart_q;
    logic        gameend_q;
    logic        enable_q;
    logic        busy_q;
    logic [7:0]  mole_pos_q;
    logic [7:0]  rounds_left_q;

    mole_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i      (CLK100MHZ),
        .rst_i      (reset),
        .prev_idx_i (prev_idx_q),
        .idx_o      (idx)
    );

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 32'd0;
            prev_idx_q    <= 3'd0;
            gamestart_q   <= 1'b0;
            gameend_q     <= 1'b0;
            enable_q      <= 1'b0;
            busy_q        <= 1'b0;
            mole_pos_q    <= 8'd0;
            rounds_left_q <= 8'd0;
        end else begin
            enable_q <= 1'b0;
            if (bus.abort) begin
                state_q       <= IDLE;
                cnt_q         <= 32'd0;
                gamestart_q   <= 1'b0;
                gameend_q     <= 1'b0;
                busy_q        <= 1'b0;
                mole_pos_q    <= 8'd0;
                rounds_left_q <= 8'd0;
            end else begin
                unique case (state_q)
                    IDLE, CLEAR: begin
                        if (state_q == CLEAR || bus.start) begin
                            state_q       <= ARM;
                            cnt_q         <= ARM_LOAD;
                            rounds_left_q <= ROUNDS_LOAD;
                            gamestart_q   <= 1'b1;
                            gameend_q     <= 1'b0;
                            busy_q        <= 1'b1;
                        end
                    end
                    ARM, GAP: begin
                        if (cnt_q != 32'd0) begin
                            cnt_q <= cnt_q - 32'd1;
                        end else if (state_q == GAP && rounds_left_q == 8'd0) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            gameend_q <= 1'b1;
                        end else begin
                            state_q       <= SHOW_ENTRY;
                            cnt_q         <= SHOW_LOAD;
                            mole_pos_q    <= 8'd1 << idx;
                            prev_idx_q    <= idx;
                            enable_q      <= 1'b1;
                            rounds_left_q <= rounds_left_q - 8'd1;
                        end
                    end
                    SHOW_ENTRY: state_q <= SHOW;
                    SHOW: begin
                        // a hit only counts once the scorer has latched the mole
                        if (cnt_q == 32'd0 || bus.molehit != 8'd0) begin
                            state_q    <= GAP_ENTRY;
                            cnt_q      <= GAP_LOAD;
                            mole_pos_q <= 8'd0;
                            enable_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                    GAP_ENTRY: state_q <= GAP;
                    DONE: begin
                        if (bus.start) begin
                            state_q     <= CLEAR;
                            gamestart_q <= 1'b0;
                            gameend_q   <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.gamestart   = gamestart_q;
    assign bus.gameend     = gameend_q;
    assign bus.enable      = enable_q;
    assign bus.busy        = busy_q;
    assign bus.mole_pos    = mole_pos_q;
    assign bus.rounds_left = rounds_left_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed and randomized checks of game_sequencer against a phase-level model
module tb_game_sequencer;

    localparam int ARM = 4;
    localparam int SHW = 10;
    localparam int GAP = 3;
    localparam int NR  = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int P_IDLE  = 0;
    localparam int P_ARM   = 1;
    localparam int P_SHOW  = 2;
    localparam int P_GAP   = 3;
    localparam int P_DONE  = 4;
    localparam int P_CLEAR = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_sequencer_if bus();

    game_sequencer #(
        .ARM_CYCLES  (ARM),
        .SHOW_CYCLES (SHW),
        .GAP_CYCLES  (GAP),
        .NUM_ROUNDS  (NR),
        .SEED        (SEED)
    ) dut (
        .CLK100MHZ (clk),
        .reset     (rst),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: the game as phases with an age since phase entry; entry cycles belong to their phase
    int          m_phase;
    int          m_age;
    int          m_rounds;
    int          m_prev;
    int          m_idx;
    int          games_done;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic enter_show(input logic [15:0] pre);
        int idx;
        idx = int'(pre) % 8;
        if (idx == m_prev) idx = (idx + 1) % 8;
        m_prev   = idx;
        m_idx    = idx;
        m_rounds = m_rounds - 1;
        m_phase  = P_SHOW;
        m_age    = 0;
    endtask

    task automatic model_edge(input logic st, input logic ab, input logic [7:0] hit);
        logic [15:0] pre;
        pre    = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        if (ab) begin
            m_phase  = P_IDLE;
            m_age    = 0;
            m_rounds = 0;
            return;
        end
        case (m_phase)
            P_IDLE:  if (st) begin m_phase = P_ARM; m_age = 0; m_rounds = NR; end
            P_ARM:   if (m_age == ARM - 1) enter_show(pre); else m_age++;
            P_SHOW:  if (m_age == SHW || (m_age >= 1 && hit != 8'd0)) begin
                         m_phase = P_GAP; m_age = 0;
                     end else m_age++;
            P_GAP:   if (m_age == GAP) begin
                         if (m_rounds > 0) enter_show(pre);
                         else begin m_phase = P_DONE; games_done++; end
                     end else m_age++;
            P_DONE:  if (st) m_phase = P_CLEAR;
            P_CLEAR: begin m_phase = P_ARM; m_age = 0; m_rounds = NR; end
            default: m_phase = P_IDLE;
        endcase
    endtask

    function automatic logic [19:0] exp_vec();
        logic       gs, ge, en, bz;
        logic [7:0] mp;
        gs = (m_phase != P_IDLE) && (m_phase != P_CLEAR);
        ge = (m_phase == P_DONE);
        en = (m_phase == P_SHOW || m_phase == P_GAP) && m_age == 0;
        bz = (m_phase == P_ARM || m_phase == P_SHOW || m_phase == P_GAP);
        mp = (m_phase == P_SHOW) ? 8'(1 << m_idx) : 8'h00;
        return {gs, ge, en, bz, mp, 8'(m_rounds)};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {bus.gamestart, bus.gameend, bus.enable, bus.busy, bus.mole_pos, bus.rounds_left};
    endfunction

    // One clock: inputs set beforehand are seen at the edge, then cleared (they are pulses)
    task automatic cyc();
        @(posedge clk);
        model_edge(bus.start, bus.abort, bus.molehit);
        @(negedge clk);
        check("outputs", 32'(dut_vec()), 32'(exp_vec()));
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.molehit = 8'd0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.molehit = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(dut_vec()), 32'd0);
        m_lfsr   = SEED;
        m_phase  = P_IDLE;
        m_age    = 0;
        m_rounds = 0;
        m_prev   = 0;
        rst      = 1'b0;
    endtask

    task automatic wait_enable(input int limit, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.enable && n < limit);
    endtask

    int exp_gap [5] = '{SHW + 1, GAP + 1, SHW + 1, GAP + 1, SHW + 1};
    int n;
    int budget;

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.molehit = 8'd0;
        games_done  = 0;
        do_reset();

        repeat (20) cyc();
        check("idle_outputs", 32'(dut_vec()), 32'd0);

        bus.start = 1'b1;
        cyc();
        check("start_gamestart", 32'(bus.gamestart), 32'd1);
        check("start_busy", 32'(bus.busy), 32'd1);
        wait_enable(50, n);
        check("arm_latency", n, ARM);
        check("first_mole_onehot", $countones(bus.mole_pos), 1);
        check("first_rounds_left", 32'(bus.rounds_left), NR - 1);

        for (int i = 0; i < 5; i++) begin
            wait_enable(50, n);
            check("strobe_spacing", n, exp_gap[i]);
            check("strobe_kind", 32'(bus.mole_pos != 8'd0), 32'(i % 2 == 1));
        end
        repeat (GAP + 1) cyc();
        check("done_gameend", 32'(bus.gameend), 32'd1);
        check("done_mole", 32'(bus.mole_pos), 32'd0);
        check("done_rounds", 32'(bus.rounds_left), 32'd0);
        repeat (5) cyc();
        check("done_gamestart_held", 32'(bus.gamestart), 32'd1);
        check("done_not_busy", 32'(bus.busy), 32'd0);

        bus.start = 1'b1;
        cyc();
        check("clear_gamestart", 32'(bus.gamestart), 32'd0);
        cyc();
        check("rearm_gamestart", 32'(bus.gamestart), 32'd1);
        check("rearm_busy", 32'(bus.busy), 32'd1);
        check("rearm_rounds", 32'(bus.rounds_left), NR);

        wait_enable(50, n);
        cyc();
        cyc();
        bus.molehit = bus.mole_pos;
        wait_enable(3, n);
        check("hit_clear_within_2", 32'(n <= 2), 32'd1);
        check("hit_clear_enable", 32'(bus.enable), 32'd1);
        check("hit_clear_mole", 32'(bus.mole_pos), 32'd0);
        wait_enable(50, n);
        check("hit_next_mole_gap", n, GAP + 1);
        check("hit_next_is_mole", 32'(bus.mole_pos != 8'd0), 32'd1);

        cyc();
        bus.abort = 1'b1;
        cyc();
        check("abort_in_show", 32'(dut_vec()), 32'd0);

        bus.start = 1'b1;
        cyc();
        wait_enable(50, n);
        cyc();
        bus.abort = 1'b1;
        bus.start = 1'b1;
        cyc();
        check("abort_with_start", 32'(dut_vec()), 32'd0);
        repeat (3) cyc();
        check("abort_stays_idle", 32'(dut_vec()), 32'd0);

        bus.start = 1'b1;
        cyc();
        n = 0;
        while (!(bus.enable && bus.mole_pos == 8'd0) && n < 100) begin
            cyc();
            n++;
        end
        check("reach_gap", 32'(n < 100), 32'd1);
        cyc();
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_mid_gap", 32'(dut_vec()), 32'd0);
        do_reset();

        games_done = 0;
        budget     = 0;
        while (games_done < 1000 && budget < 80000) begin
            if ((m_phase == P_IDLE || m_phase == P_DONE) && $urandom_range(1, 2) == 1)
                bus.start = 1'b1;
            if ($urandom_range(1, 500) == 1)
                bus.abort = 1'b1;
            if (m_phase == P_SHOW && $urandom_range(1, 6) == 1)
                bus.molehit = exp_vec()[15:8];
            else if ($urandom_range(1, 20) == 1)
                bus.molehit = 8'($urandom_range(1, 255));
            cyc();
            budget++;
        end
        check("random_games_completed", games_done, 1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level round controller that drives the mole score tracker. It generates the `gamestart`/`gameend` levels, the `enable` strobe and the mole-position vector.
- It runs a countdown, then `NUM_ROUNDS` show/gap rounds with pseudo-random one-hot mole placement.
- Game flow, score reset and mole timing all originate here.
- It sits between the button/debounce logic and the scorer; `molehit` returns from the scorer for early round termination.

Parameters:
- ARM_CYCLES, 300_000_000, countdown length in clocks after start (3 s at 100 MHz).
- SHOW_CYCLES, 100_000_000, maximum clocks a mole stays up.
- GAP_CYCLES, 25_000_000, clocks with no mole between rounds.
- NUM_ROUNDS, 30, rounds per game; legal range 1..255.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.

Ports:
- CLK100MHZ  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle start pulse (debounced)
- abort  in  1  single-cycle abort pulse
- molehit  in  8  hit indication from scorer; nonzero = current mole hit
- gamestart  out  1  level; 0 clears scorer score
- gameend  out  1  level; 1 in DONE
- enable  out  1  single-cycle strobe; scorer latches mole_pos when high
- mole_pos  out  8  one-hot mole, or 0 to clear
- rounds_left  out  8  rounds not yet started
- busy  out  1  high in ARM/SHOW/GAP

Behaviour:
- Reset (async, any time, including mid-game):
  - State is IDLE.
  - All outputs are 0 and rounds_left = 0.
  - Cycle counter is 0 and LFSR = SEED.
- Outputs are registered, with one cycle of latency from the state transition.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Free-running every cycle from reset, so its value depends on when the player presses start.
- States:
  - IDLE: gamestart=0, gameend=0. `start` → ARM; load counter = ARM_CYCLES-1 and rounds_left = NUM_ROUNDS.
  - ARM: gamestart=1, busy=1. Counter decrements to 0 → SHOW entry.
  - SHOW entry, one cycle:
    - idx = LFSR[2:0]. If idx equals the previous mole index, use idx+1 mod 8 (no immediate repeat).
    - mole_pos = 1<<idx and enable=1 for exactly that cycle.
    - rounds_left decrements; counter = SHOW_CYCLES-1.
  - SHOW: mole_pos held. Exit to GAP entry when the counter reaches 0, or on the first cycle after entry with molehit != 0.
  - GAP entry, one cycle: mole_pos=0, enable=1, counter = GAP_CYCLES-1.
  - GAP: counter reaches 0 → SHOW entry if rounds_left != 0, else DONE.
  - DONE: gamestart=1 (score preserved), gameend=1, busy=0, mole_pos=0. `start` → CLEAR.
  - CLEAR: exactly one cycle with gamestart=0 (scorer zeroes score), then ARM with reload as from IDLE.
- Priority and ignored inputs:
  - abort has priority over everything except reset. abort in any state → IDLE next cycle: gamestart=0, enable=0, mole_pos=0.
  - When start and abort coincide, abort wins.
  - start is ignored in ARM, SHOW and GAP.
  - molehit is ignored in the SHOW-entry cycle (the scorer is still latching) and in every state other than SHOW.
- Counter width:
  - Counter is 32 bits, wide enough for the largest parameter.
  - A parameter value of 1 gives a state duration of one cycle after entry; 0 is illegal (elaboration assertion).
- enable is never high on two consecutive cycles; minimum spacing is 2 cycles.

Decomposition:
- Package `game_pkg`:
  - State enum: IDLE, ARM, SHOW_ENTRY, SHOW, GAP_ENTRY, GAP, DONE, CLEAR.
  - Default timing constants and the LFSR tap mask.
- One sub-module, `mole_lfsr`: 16-bit Galois LFSR plus no-repeat index selection. Output is a 3-bit index; input is the previous index.

Test Plan:
All scenarios use ARM_CYCLES=4, SHOW_CYCLES=10, GAP_CYCLES=3, NUM_ROUNDS=3, SEED=16'hACE1.
- Reset, then idle 20 cycles → all outputs 0; start pulse → gamestart=1 and busy=1 next cycle; first enable 4 cycles later with one-hot mole_pos; rounds_left=2.
- No hits → enable pattern of 3 mole strobes and 3 clear strobes spaced 11/4 cycles; then gameend=1, mole_pos=0, rounds_left=0, gamestart stays 1.
- molehit=mole_pos 3 cycles after SHOW entry → clear strobe (enable=1, mole_pos=0) within 2 cycles; round is not extended.
- Force LFSR idx equal to the previous index → new mole_pos is rotated left by 1; never the same bit on consecutive rounds over 1000 games.
- start in DONE → gamestart=0 for exactly 1 cycle, then ARM; scorer score reads 0.
- abort during SHOW, and abort with start in the same cycle → IDLE next cycle, all outputs 0; async reset mid-GAP → outputs 0 immediately, before the next clock edge.
